// File: rtl/fprint_write_arbiter.sv
// Round-robin write arbiter: per-core one-entry Avalon-MM write buffers
// drained onto the single CFPU fingerprint write port, tagged by core index.
module fprint_write_arbiter #(
  parameter int NUM_CORES        = 2,
  parameter int LOCAL_ADDR_WIDTH = 4,
  parameter int CORE_ID_WIDTH    = 4,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CORES*LOCAL_ADDR_WIDTH-1:0]    s_address,
  input  logic [NUM_CORES-1:0]                     s_write,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]          s_writedata,
  output logic [NUM_CORES-1:0]                     s_waitrequest,
  output logic [CORE_ID_WIDTH+LOCAL_ADDR_WIDTH-1:0] m_address,
  output logic                                     m_write,
  output logic [DATA_WIDTH-1:0]                    m_writedata,
  input  logic                                     m_waitrequest,
  output logic                                     busy
);

  localparam int MAW = CORE_ID_WIDTH + LOCAL_ADDR_WIDTH;

  typedef logic [CORE_ID_WIDTH-1:0] idx_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t                      state_q, state_d;
  logic [NUM_CORES-1:0]        valid_q;
  logic [LOCAL_ADDR_WIDTH-1:0] addr_q [NUM_CORES];
  logic [DATA_WIDTH-1:0]       data_q [NUM_CORES];
  idx_t                        last_grant_q, last_grant_d;
  idx_t                        grant_q, grant_d;

  logic [NUM_CORES-1:0]        accept;
  logic [NUM_CORES-1:0]        drain;
  logic [NUM_CORES-1:0]        grant_oh;
  logic                        load;
  pick_t                       pk;
  logic [LOCAL_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]       sel_data;
  logic [MAW-1:0]              m_address_d;
  logic                        m_write_d;
  logic [DATA_WIDTH-1:0]       m_writedata_d;

  // First set bit of req searching upward from base+1, wrapping at NUM_CORES.
  function automatic pick_t rr_pick(
    input logic [NUM_CORES-1:0] req,
    input idx_t                 base
  );
    pick_t r;
    r = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      for (int j = 0; j < NUM_CORES; j++) begin
        if (!r.found && req[j] &&
            (j == ((int'(base) + k) % NUM_CORES))) begin
          r.found = 1'b1;
          r.idx   = idx_t'(j);
        end
      end
    end
    return r;
  endfunction

  assign s_waitrequest = valid_q;
  assign busy          = (|valid_q) | m_write;

  // A core's write is taken only while its buffer is empty.
  always_comb begin
    accept = s_write & ~valid_q;
  end

  // One-hot of the currently granted core.
  always_comb begin
    grant_oh = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (idx_t'(j) == grant_q) grant_oh[j] = 1'b1;
    end
  end

  // Buffer contents of the core about to be granted.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      if (idx_t'(j) == grant_d) begin
        sel_addr = addr_q[j];
        sel_data = data_q[j];
      end
    end
  end

  // Arbiter next state, grant selection and master output loading.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    drain         = '0;
    load          = 1'b0;
    pk            = '0;
    m_write_d     = m_write;
    m_address_d   = m_address;
    m_writedata_d = m_writedata;
    unique case (state_q)
      IDLE: begin
        m_write_d = 1'b0;
        pk = rr_pick(valid_q, last_grant_q);
        if (pk.found) begin
          load      = 1'b1;
          grant_d   = pk.idx;
          m_write_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_waitrequest) begin
          drain        = grant_oh;
          last_grant_d = grant_q;
          pk = rr_pick(valid_q & ~grant_oh, grant_q);
          if (pk.found) begin
            load      = 1'b1;
            grant_d   = pk.idx;
            m_write_d = 1'b1;
          end else begin
            m_write_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
    endcase
    if (load) begin
      m_address_d   = {grant_d, sel_addr};
      m_writedata_d = sel_data;
    end
  end

  // Per-core holding buffers: fill on accept, empty on master handoff.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= (valid_q & ~drain) | accept;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (accept[i]) begin
          addr_q[i] <= s_address[i*LOCAL_ADDR_WIDTH +: LOCAL_ADDR_WIDTH];
          data_q[i] <= s_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Arbiter state and registered master outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= idx_t'(NUM_CORES - 1);
      grant_q      <= '0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      m_write      <= m_write_d;
      m_address    <= m_address_d;
      m_writedata  <= m_writedata_d;
    end
  end

endmodule

// File: tb/tb_fprint_write_arbiter.sv
// Bench for fprint_write_arbiter: expected master transfers are queued as
// stimulus is driven and matched against transfers seen on the master port.
module tb_fprint_write_arbiter;

  localparam int N   = 4;
  localparam int LAW = 4;
  localparam int CIW = 4;
  localparam int DW  = 32;
  localparam int MAW = CIW + LAW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           sw [N];
  logic [LAW-1:0] sa [N];
  logic [DW-1:0]  sd [N];

  logic [N*LAW-1:0] s_address;
  logic [N-1:0]     s_write;
  logic [N*DW-1:0]  s_writedata;
  logic [N-1:0]     s_waitrequest;
  logic [MAW-1:0]   m_address;
  logic             m_write;
  logic [DW-1:0]    m_writedata;
  logic             m_waitrequest;
  logic             busy;

  always_comb begin
    s_write     = '0;
    s_address   = '0;
    s_writedata = '0;
    for (int i = 0; i < N; i++) begin
      s_write[i]               = sw[i];
      s_address[i*LAW +: LAW]  = sa[i];
      s_writedata[i*DW +: DW]  = sd[i];
    end
  end

  fprint_write_arbiter #(
    .NUM_CORES(N),
    .LOCAL_ADDR_WIDTH(LAW),
    .CORE_ID_WIDTH(CIW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .s_address(s_address),
    .s_write(s_write),
    .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest),
    .m_address(m_address),
    .m_write(m_write),
    .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit tmo;
  logic [MAW+DW-1:0] exp_q[$];
  logic [MAW+DW-1:0] obs_q[$];

  // Transfers that will be accepted at the coming rising edge.
  always @(negedge clk) begin
    if (!reset && m_write && !m_waitrequest)
      obs_q.push_back({m_address, m_writedata});
  end

  task automatic do_reset();
    reset = 1'b1;
    m_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) begin
      sw[i] = 1'b0;
      sa[i] = '0;
      sd[i] = '0;
    end
    exp_q.delete();
    obs_q.delete();
    tmo = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic write_core(input int i, input logic [LAW-1:0] a,
                            input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    sa[i] = a;
    sd[i] = d;
    sw[i] = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (!s_waitrequest[i]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) tmo = 1'b1;
    sw[i] = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) begin
      sw[i] = 1'b0;
      sa[i] = '0;
      sd[i] = '0;
    end
    #1;
    checks++;
    if (s_waitrequest !== '0 || m_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got wr=%b mw=%b busy=%b want 0/0/0",
               s_waitrequest, m_write, busy);
    end
    checks++;
    if (m_address !== '0 || m_writedata !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h d=%h want 0/0",
               m_address, m_writedata);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got mw=%b busy=%b want 0/0",
               m_write, busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [MAW+DW-1:0] e, o;
    do_reset();
    exp_q.push_back({8'h13, 32'hDEADBEEF});
    sa[1] = 4'h3;
    sd[1] = 32'hDEADBEEF;
    sw[1] = 1'b1;
    @(posedge clk);
    #1 sw[1] = 1'b0;
    checks++;
    if (s_waitrequest[1] !== 1'b1 || m_write !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got wr=%b mw=%b want 1/0",
               s_waitrequest[1], m_write);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b1 || m_address !== 8'h13 ||
        m_writedata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_issue got mw=%b a=%h d=%h want 1/13/deadbeef",
               m_write, m_address, m_writedata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got mw=%b want 0", m_write);
    end
    wait_idle(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d want %0d ok=%0b",
               obs_q.size(), exp_q.size(), ok);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single_word got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [MAW+DW-1:0] e, o;
    do_reset();
    exp_q.push_back({8'h00, 32'hA});
    exp_q.push_back({8'h10, 32'hB});
    sd[0] = 32'hA;
    sd[1] = 32'hB;
    sw[0] = 1'b1;
    sw[1] = 1'b1;
    @(posedge clk);
    #1;
    sw[0] = 1'b0;
    sw[1] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b1 || m_address !== 8'h00) begin
      errors++;
      $display("FAIL simul_first got mw=%b a=%h want 1/00", m_write, m_address);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b1 || m_address !== 8'h10 || m_writedata !== 32'hB) begin
      errors++;
      $display("FAIL simul_second got mw=%b a=%h d=%h want 1/10/b",
               m_write, m_address, m_writedata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0) begin
      errors++;
      $display("FAIL simul_end got mw=%b want 0", m_write);
    end
    wait_idle(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL simul_count got %0d want %0d ok=%0b",
               obs_q.size(), exp_q.size(), ok);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL simul_word got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit done;
    logic [MAW+DW-1:0] e, o;
    do_reset();
    m_waitrequest = 1'b1;
    exp_q.push_back({8'h05, 32'h1111_0001});
    exp_q.push_back({8'h06, 32'h1111_0002});
    sa[0] = 4'h5;
    sd[0] = 32'h1111_0001;
    sw[0] = 1'b1;
    @(posedge clk);
    #1;
    sa[0] = 4'h6;
    sd[0] = 32'h1111_0002;
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b1 || m_address !== 8'h05 ||
        m_writedata !== 32'h1111_0001) begin
      errors++;
      $display("FAIL bp_issue got mw=%b a=%h d=%h want 1/05/11110001",
               m_write, m_address, m_writedata);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if (m_write !== 1'b1 || m_address !== 8'h05 ||
          m_writedata !== 32'h1111_0001 || s_waitrequest[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold got mw=%b a=%h d=%h wr=%b want 1/05/11110001/1",
                 m_write, m_address, m_writedata, s_waitrequest[0]);
      end
    end
    m_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b0 || s_waitrequest[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got mw=%b wr=%b want 0/0",
               m_write, s_waitrequest[0]);
    end
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!s_waitrequest[0]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    sw[0] = 1'b0;
    wait_idle(ok);
    checks++;
    if (!done || !ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d ok=%0b/%0b",
               obs_q.size(), exp_q.size(), done, ok);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bp_word got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [MAW+DW-1:0] e, o;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back({4'h0, LAW'(k), 32'h100 + 32'(k)});
      exp_q.push_back({4'h1, LAW'(k), 32'h200 + 32'(k)});
    end
    fork
      begin
        for (int k = 0; k < 20; k++)
          write_core(0, LAW'(k), 32'h100 + 32'(k));
      end
      begin
        for (int k = 0; k < 20; k++)
          write_core(1, LAW'(k), 32'h200 + 32'(k));
      end
    join
    wait_idle(ok);
    checks++;
    if (tmo || !ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fair_count got %0d want %0d tmo=%0b ok=%0b",
               obs_q.size(), exp_q.size(), tmo, ok);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fair_word got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [MAW+DW-1:0] e, o;
    do_reset();
    m_waitrequest = 1'b1;
    sa[0] = 4'h2;
    sd[0] = 32'h5555_AAAA;
    sw[0] = 1'b1;
    @(posedge clk);
    #1 sw[0] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got mw=%b busy=%b want 1/1", m_write, busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (m_write !== 1'b0 || busy !== 1'b0 || s_waitrequest !== '0 ||
        m_address !== '0 || m_writedata !== '0) begin
      errors++;
      $display("FAIL rmid_clear got mw=%b busy=%b wr=%b a=%h d=%h want all 0",
               m_write, busy, s_waitrequest, m_address, m_writedata);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_waitrequest = 1'b0;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({8'h01, 32'hC0});
    exp_q.push_back({8'h11, 32'hC1});
    sa[0] = 4'h1;
    sd[0] = 32'hC0;
    sa[1] = 4'h1;
    sd[1] = 32'hC1;
    sw[0] = 1'b1;
    sw[1] = 1'b1;
    @(posedge clk);
    #1;
    sw[0] = 1'b0;
    sw[1] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (m_write !== 1'b1 || m_address[MAW-1:LAW] !== 4'h0) begin
      errors++;
      $display("FAIL rmid_first_grant got mw=%b core=%h want 1/0",
               m_write, m_address[MAW-1:LAW]);
    end
    wait_idle(ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rmid_count got %0d want %0d ok=%0b",
               obs_q.size(), exp_q.size(), ok);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rmid_word got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok1, ok2;
    logic [MAW+DW-1:0] e, o;
    do_reset();
    exp_q.push_back({8'h27, 32'hC2});
    exp_q.push_back({8'h37, 32'hC3});
    exp_q.push_back({8'h07, 32'hC0});
    write_core(2, 4'h7, 32'hC2);
    wait_idle(ok1);
    sa[3] = 4'h7;
    sd[3] = 32'hC3;
    sa[0] = 4'h7;
    sd[0] = 32'hC0;
    sw[3] = 1'b1;
    sw[0] = 1'b1;
    @(posedge clk);
    #1;
    sw[3] = 1'b0;
    sw[0] = 1'b0;
    wait_idle(ok2);
    checks++;
    if (tmo || !ok1 || !ok2 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count got %0d want %0d tmo=%0b ok=%0b/%0b",
               obs_q.size(), exp_q.size(), tmo, ok1, ok2);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_word got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
